cla_addsub_pipe: RTL

//  Parametrised two-stage pipelined carry-lookahead adder/subtractor for the datapath ALU.

---
 rtl/cla_addsub_pipe_pkg.sv | 41 ++++
 rtl/cla_addsub_pipe_group.sv | 30 +++
 rtl/cla_addsub_pipe.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cla_addsub_pipe_pkg.sv
// Shared definitions for the pipelined CLA adder/subtractor: op encoding, default sizes,
// flag bundle and the lookahead carry equation used by both pipeline stages.
package cla_addsub_pipe_pkg;

  typedef enum logic {
    ALU_OP_ADD = 1'b0,
    ALU_OP_SUB = 1'b1
  } alu_op_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_GROUP = 4;
  // Widest P/G vector la_carry accepts; bounds both GROUP and the number of groups.
  localparam int LA_MAX    = 64;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

  // Carry into position pos of a block: OR over i<pos of g[i] & p[pos-1:i+1], plus the
  // all-propagate term with cin. Sum-of-products form, so no ripple chain between bits.
  function automatic logic la_carry(input logic [LA_MAX-1:0] p,
                                    input logic [LA_MAX-1:0] g,
                                    input logic              cin,
                                    input int                pos);
    logic carry;
    logic run;
    carry = 1'b0;
    run   = 1'b1;
    for (int i = LA_MAX - 1; i >= 0; i--) begin
      if (i < pos) begin
        carry = carry | (g[i] & run);
        run   = run & p[i];
      end
    end
    return carry | (run & cin);
  endfunction

endpackage

// File: rtl/cla_addsub_pipe_group.sv
// GROUP-bit carry-lookahead block: forms every in-group carry directly from P/G and the
// group carry-in, then the sum bits.
module cla_addsub_pipe_group
  import cla_addsub_pipe_pkg::*;
#(
  parameter int GROUP = DEF_GROUP
) (
  input  logic [GROUP-1:0] p_i,
  input  logic [GROUP-1:0] g_i,
  input  logic             c_i,
  output logic [GROUP-1:0] sum_o
);

  logic [LA_MAX-1:0] p_ext;
  logic [LA_MAX-1:0] g_ext;

  always_comb begin
    // NOTE: every variable written here gets a value before any condition or loop, so no
    // path can leave one unassigned and synthesis never infers a latch.
    p_ext              = '0;
    g_ext              = '0;
    sum_o              = '0;
    p_ext[GROUP-1:0]   = p_i;
    g_ext[GROUP-1:0]   = g_i;
    for (int i = 0; i < GROUP; i++) begin
      sum_o[i] = p_i[i] ^ la_carry(p_ext, g_ext, c_i, i);
    end
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit and group P/G; stage 2 resolves group carries, registers sum and flags.
module cla_addsub_pipe
  import cla_addsub_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int GROUP = DEF_GROUP
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int NG = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0 || GROUP > LA_MAX || NG > LA_MAX) begin : g_bad_params
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and both fit LA_MAX");
  end

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [NG-1:0]    pg_q, pg_d;
  logic [NG-1:0]    gg_q, gg_d;
  logic             c0_q, c0_d;

  // Stage 2 state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  flags_t           flags_q, flags_d;

  logic             s1_ready;
  logic             s2_ready;
  logic             is_sub;
  logic [WIDTH-1:0] bx;
  logic [NG:0]      gc;
  logic [WIDTH-1:0] sum_w;

  // Ready only looks downstream, so in_valid never reaches in_ready combinationally.
  assign s2_ready = !out_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;

  assign is_sub = (alu_op_e'(in_sub) == ALU_OP_SUB);
  assign bx     = is_sub ? ~in_b : in_b;

  always_comb begin
    logic [LA_MAX-1:0] gp_x;
    logic [LA_MAX-1:0] gg_x;
    s1_valid_d = s1_valid_q;
    p_d        = p_q;
    g_d        = g_q;
    pg_d       = pg_q;
    gg_d       = gg_q;
    c0_d       = c0_q;
    gp_x       = '0;
    gg_x       = '0;
    if (s1_ready) begin
      s1_valid_d = in_valid;
    end
    if (s1_ready && in_valid) begin
      p_d  = in_a ^ bx;
      g_d  = in_a & bx;
      c0_d = is_sub ? 1'b1 : in_cin;
      for (int k = 0; k < NG; k++) begin
        gp_x              = '0;
        gg_x              = '0;
        gp_x[GROUP-1:0]   = p_d[k*GROUP +: GROUP];
        gg_x[GROUP-1:0]   = g_d[k*GROUP +: GROUP];
        pg_d[k]           = &p_d[k*GROUP +: GROUP];
        gg_d[k]           = la_carry(gp_x, gg_x, 1'b0, GROUP);
      end
    end
  end

  // Group carries: each one a flat function of PG/GG and c0, never of another group carry.
  always_comb begin
    logic [LA_MAX-1:0] pg_x;
    logic [LA_MAX-1:0] gg_x;
    pg_x         = '0;
    gg_x         = '0;
    pg_x[NG-1:0] = pg_q;
    gg_x[NG-1:0] = gg_q;
    gc           = '0;
    gc[0]        = c0_q;
    for (int k = 1; k <= NG; k++) begin
      gc[k] = la_carry(pg_x, gg_x, c0_q, k);
    end
  end

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_addsub_pipe_group #(
      .GROUP (GROUP)
    ) u_grp (
      .p_i   (p_q[k*GROUP +: GROUP]),
      .g_i   (g_q[k*GROUP +: GROUP]),
      .c_i   (gc[k]),
      .sum_o (sum_w[k*GROUP +: GROUP])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    flags_d     = flags_q;
    if (s2_ready) begin
      out_valid_d = s1_valid_q;
    end
    if (s2_ready && s1_valid_q) begin
      sum_d         = sum_w;
      flags_d.cout  = gc[NG];
      // Carry into the MSB is recovered as sum ^ propagate at that bit.
      flags_d.ovf   = gc[NG] ^ (sum_w[WIDTH-1] ^ p_q[WIDTH-1]);
      flags_d.zero  = (sum_w == '0);
      flags_d.neg   = sum_w[WIDTH-1];
    end
  end

  // NOTE: data registers are reset along with the valid bits so that nothing from before
  // clr can ever be observed on the outputs afterwards.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      pg_q        <= '0;
      gg_q        <= '0;
      c0_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      flags_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample pre-edge values, so data
      // moves exactly one stage per clock regardless of statement order.
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      g_q         <= g_d;
      pg_q        <= pg_d;
      gg_q        <= gg_d;
      c0_q        <= c0_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = flags_q.cout;
  assign out_ovf   = flags_q.ovf;
  assign out_zero  = flags_q.zero;
  assign out_neg   = flags_q.neg;

endmodule
